// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master that streams a block of on-chip memory words out as
// Avalon-ST beats through a small credit-managed FIFO.
module onchip_mem_stream_reader #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_last
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic              pending;
  logic              pending_last;
  logic              done_next;
  logic              load;
  logic              issue;
  logic              issue_last;
  logic              credit_ok;
  logic [FCNT_W:0]   credit_sum;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] fifo_count;
  logic              push;
  logic              pop;
  logic              head_last;

  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

  // A slot is reserved for every read in flight so a returning word always fits.
  assign credit_sum = {1'b0, fifo_count} + (FCNT_W + 1)'(pending);
  assign credit_ok  = credit_sum < (FCNT_W + 1)'(FIFO_DEPTH);

  assign src_valid = (fifo_count != '0);
  assign src_data  = fifo_data[rd_ptr];
  assign head_last = fifo_last[rd_ptr];
  assign src_last  = src_valid & head_last;

  assign pop  = src_valid & src_ready;
  assign push = pending;

  assign busy           = (state != IDLE);
  assign mem_chipselect = issue;
  assign mem_address    = addr;
  assign issue_last     = issue && (remaining == CNT_W'(1));

  always_comb begin
    state_next = state;
    load       = 1'b0;
    issue      = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            load       = 1'b1;
            state_next = RUN;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if ((remaining != '0) && credit_ok) begin
          issue = 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr         <= '0;
      remaining    <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      pending      <= issue;
      pending_last <= issue_last;
      if (load) begin
        addr      <= start_addr;
        remaining <= word_count;
      end else if (issue) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
      end
      fifo_last  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_readdata;
        fifo_last[wr_ptr] <= pending_last;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Self-checking bench: table-driven per-cycle vectors plus hand-written
// stall, random-backpressure and mid-transfer reset sequences.
module tb_onchip_mem_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] start_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic [14:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic        mem_clken;
  logic [31:0] mem_readdata = 32'h0;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic        src_last;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  onchip_mem_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .src_last(src_last)
  );

  function automatic logic [31:0] m_word(input logic [14:0] a);
    return 32'hA500_0000 + {17'd0, a};
  endfunction

  // Memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= m_word(mem_address);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        start;
    logic [14:0] sa;
    logic [15:0] wc;
    logic        rdy;
    logic        busy;
    logic        done;
    logic        cs;
    logic [14:0] addr;
    logic        valid;
    logic [31:0] data;
    logic        last;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic [14:0] sa, input logic [15:0] wc,
                              input logic rdy, input logic b, input logic d, input logic cs,
                              input logic [14:0] ad, input logic v, input logic [31:0] dt,
                              input logic l);
    vec_t r;
    r.start = st; r.sa = sa; r.wc = wc; r.rdy = rdy;
    r.busy = b; r.done = d; r.cs = cs; r.addr = ad; r.valid = v; r.data = dt; r.last = l;
    return r;
  endfunction

  task automatic collect(input logic [14:0] a0, input int n, input bit rnd, input bit poke);
    int got = 0;
    int lasts = 0;
    int cyc = 0;
    bit seen_done = 0;
    logic [14:0] a;
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen_done = 1;
        chk("busy_low_with_done", {31'd0, busy}, 32'd0);
      end else begin
        src_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (poke) begin
          start      = 1'($urandom_range(0, 1));
          start_addr = 15'h5555;
          word_count = 16'd7;
        end
        if (src_valid && src_ready) begin
          a = a0 + 15'(got);
          chk("beat_data", src_data, m_word(a));
          chk("beat_last", {31'd0, src_last}, {31'd0, (got == n - 1)});
          if (src_last) lasts++;
          got++;
        end
      end
    end
    start = 1'b0;
    chk("done_seen", {31'd0, seen_done}, 32'd1);
    chk("beat_count", got, n);
    chk("last_count", lasts, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    int got;

    // Basic 5-word transfer, with a start poke while busy that must be ignored.
    vecs.push_back(mk(1, 15'h0010, 16'd5, 1, 1, 0, 1, 15'h0010, 0, 32'h0, 0));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 1, 0, 1, 15'h0011, 0, 32'h0, 0));
    vecs.push_back(mk(1, 15'h7777, 16'd9, 1, 1, 0, 1, 15'h0012, 1, 32'hA500_0010, 0));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 1, 0, 1, 15'h0013, 1, 32'hA500_0011, 0));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 1, 0, 1, 15'h0014, 1, 32'hA500_0012, 0));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 1, 0, 0, 15'h0000, 1, 32'hA500_0013, 0));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 1, 0, 0, 15'h0000, 1, 32'hA500_0014, 1));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 0, 1, 0, 15'h0000, 0, 32'h0, 0));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 0, 0, 0, 15'h0000, 0, 32'h0, 0));
    // Zero-length request: done only.
    vecs.push_back(mk(1, 15'h0050, 16'd0, 1, 0, 1, 0, 15'h0000, 0, 32'h0, 0));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 0, 0, 0, 15'h0000, 0, 32'h0, 0));
    // Address wrap 0x7FFE, 0x7FFF, 0x0000.
    vecs.push_back(mk(1, 15'h7FFE, 16'd3, 1, 1, 0, 1, 15'h7FFE, 0, 32'h0, 0));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 1, 0, 1, 15'h7FFF, 0, 32'h0, 0));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 1, 0, 1, 15'h0000, 1, 32'hA500_7FFE, 0));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 1, 0, 0, 15'h0000, 1, 32'hA500_7FFF, 0));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 1, 0, 0, 15'h0000, 1, 32'hA500_0000, 1));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 0, 1, 0, 15'h0000, 0, 32'h0, 0));
    vecs.push_back(mk(0, 15'h0000, 16'd0, 1, 0, 0, 0, 15'h0000, 0, 32'h0, 0));

    reset = 1'b1; start = 1'b0; start_addr = '0; word_count = '0; src_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cs", {31'd0, mem_chipselect}, 32'd0);
    chk("rst_addr", {17'd0, mem_address}, 32'd0);
    chk("rst_valid", {31'd0, src_valid}, 32'd0);
    chk("rst_last", {31'd0, src_last}, 32'd0);
    chk("rst_data", src_data, 32'd0);
    chk("const_write", {31'd0, mem_write}, 32'd0);
    chk("const_be", {28'd0, mem_byteenable}, 32'hF);
    chk("const_clken", {31'd0, mem_clken}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; start_addr = vecs[i].sa;
      word_count = vecs[i].wc; src_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vecs[i].done});
      chk($sformatf("vec%0d_cs", i), {31'd0, mem_chipselect}, {31'd0, vecs[i].cs});
      if (vecs[i].cs) chk($sformatf("vec%0d_addr", i), {17'd0, mem_address}, {17'd0, vecs[i].addr});
      chk($sformatf("vec%0d_valid", i), {31'd0, src_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("vec%0d_last", i), {31'd0, src_last}, {31'd0, vecs[i].last});
      if (vecs[i].valid) chk($sformatf("vec%0d_data", i), src_data, vecs[i].data);
    end
    start = 1'b0;

    // Stall: 12 words, sink blocked for 20 cycles.
    @(negedge clk);
    start = 1'b1; start_addr = 15'h0100; word_count = 16'd12; src_ready = 1'b0;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_chipselect) hits++;
      if (i >= 4) chk("stall_cs_low", {31'd0, mem_chipselect}, 32'd0);
      if (src_valid) chk("stall_head_stable", src_data, m_word(15'h0100));
    end
    chk("stall_reads_buffered", hits, 32'd4);
    collect(15'h0100, 12, 1'b0, 1'b0);

    // Random backpressure with start pokes while busy.
    @(negedge clk);
    start = 1'b1; start_addr = 15'h0040; word_count = 16'd100;
    collect(15'h0040, 100, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("pokes_ignored", {31'd0, busy}, 32'd0);

    // Reset in the middle of a transfer after 3 accepted words.
    @(negedge clk);
    start = 1'b1; start_addr = 15'h0200; word_count = 16'd10; src_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && got < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (src_valid && src_ready) begin
        chk("pre_reset_data", src_data, m_word(15'h0200 + 15'(got)));
        got++;
      end
    end
    chk("pre_reset_beats", got, 32'd3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_cs", {31'd0, mem_chipselect}, 32'd0);
    chk("arst_addr", {17'd0, mem_address}, 32'd0);
    chk("arst_valid", {31'd0, src_valid}, 32'd0);
    chk("arst_last", {31'd0, src_last}, 32'd0);
    chk("arst_data", src_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start = 1'b1; start_addr = 15'h0300; word_count = 16'd2;
    collect(15'h0300, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onchip_mem_stream_reader.md
# onchip_mem_stream_reader

Avalon-MM read master that sits directly downstream of the 32000×32 single-port on-chip memory and turns a block of its contents into an Avalon-ST stream. Software or a controller FSM supplies a start word address and word count; the block issues one read per cycle against the memory's fixed one-cycle read latency, buffers returned words in a small FIFO, and presents them with valid/ready backpressure. A start/busy/done handshake frames each transfer, and the last beat is flagged.

## Interface
- ADDR_W, 15, memory word-address width
- DATA_W, 32, data width
- CNT_W, 16, word-count width
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2

- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin transfer; sampled only in IDLE
- start_addr  in  ADDR_W  first word address
- word_count  in  CNT_W  number of words to read
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer completion
- mem_address  out  ADDR_W  to memory address
- mem_chipselect  out  1  read request this cycle
- mem_write  out  1  constant 0
- mem_byteenable  out  4  constant 4'hF
- mem_clken  out  1  constant 1
- mem_readdata  in  DATA_W  memory read data, valid the cycle after a request
- src_data  out  DATA_W  stream data (FIFO head)
- src_valid  out  1  FIFO non-empty
- src_ready  in  1  sink accepts beat
- src_last  out  1  head beat is final word of transfer

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 with word_count>0 latches addr←start_addr, remaining←word_count, enters RUN. start=1 with word_count=0: done pulses next cycle, no memory access, stays IDLE.
- RUN: issue read (mem_chipselect=1, mem_address=addr) when remaining>0 and fifo_count + pending < FIFO_DEPTH; on issue addr←addr+1 (modulo 2^ADDR_W, 0x7FFF→0x0000), remaining←remaining−1. Issue with remaining=1 tags the read last and moves to DRAIN.
- pending: registered flag = a read was issued last cycle; when set, mem_readdata and its last tag are pushed into the FIFO that edge.
- DRAIN: no new reads; on handshake (src_valid & src_ready & src_last) → IDLE with done pulse.
- FIFO: push and pop in the same cycle allowed; count unchanged. Credit rule guarantees no overflow; a push is never dropped.
- start while busy is ignored; start_addr/word_count may change after sampling.
- Addresses ≥32000 are caller's responsibility; block does not check.
- mem_write, mem_byteenable, mem_clken are constants, reset-independent.

## Timing
- Reset (async assert): state=IDLE, busy=0, done=0, mem_chipselect=0, mem_address=0, src_valid=0, src_last=0, src_data=0, FIFO empty, pending=0. Reset mid-transfer aborts without done; in-flight read data discarded.
- Start sampled at edge E0: after E0 busy=1, mem_chipselect=1, mem_address=start_addr. After E1 mem_readdata=M[start_addr]. After E2 src_valid=1, src_data=M[start_addr].
- With src_ready held 1: one word per cycle sustained; N-word transfer's last beat is visible after edge E(N+1), accepted at E(N+2); after that edge done=1 and busy=0 for one cycle.
- done asserts in the cycle following the last-beat handshake; busy deasserts in that same cycle; next start may be sampled in that cycle.
- src_data/src_last stable while src_valid=1 and src_ready=0.
- Stall: with src_ready=0, at most FIFO_DEPTH words buffered; mem_chipselect drops once fifo_count+pending=FIFO_DEPTH.

## Test plan
- Preload M[i]=0xA5000000+i; start_addr=0x0010, word_count=5, src_ready=1 → beats 0xA5000010..0xA5000014 on consecutive cycles, src_last only on 0xA5000014, done one cycle later, busy=0 with it.
- word_count=0 → done pulse one cycle after start, mem_chipselect never asserted, no src_valid.
- word_count=12, src_ready=0 for 20 cycles then 1 → exactly 4 words buffered, mem_chipselect low during stall, all 12 words delivered in order with no loss/duplication.
- start_addr=0x7FFE, word_count=3 → mem_address sequence 0x7FFE, 0x7FFF, 0x0000.
- Random src_ready toggling, word_count=100 → scoreboard matches memory order, one src_last, one done; start pulses during busy ignored.
- Assert reset during RUN after 3 words → all outputs at reset values immediately; new start of 2 words afterwards completes normally with no stale data.
